// File: rtl/mc6809_irq_ctrl.sv
// mc6809_irq_ctrl: memory-mapped interrupt controller for the 6809 core.
// Collects eight asynchronous request lines and synchronizes them to CLK4.
// Each source is latched on a rising edge or passed as a level, according to
// its EDGE bit. Enabled sources are steered to the active-low nIRQ or nFIRQ
// line by ROUTE.
//
// Register map (offset from BASE_ADDR):
//   0 PEND   R: pending bits, W: write-1-to-clear (edge-mode bits only)
//   1 MASK   R/W, 1 = enabled
//   2 EDGE   R/W, 1 = rising-edge latched, 0 = level
//   3 ROUTE  R/W, 1 = FIRQ, 0 = IRQ
//   4 VECTOR R, only when IRQC_VECTOR_EN is defined; otherwise reads 8'h00
//   5-7      read 8'h00, writes ignored
//
// Optional feature macro: IRQC_VECTOR_EN (priority-encoded VECTOR register).
//
// Ports:
//   CLK4   in   4x bus clock, all logic on posedge
//   RESET  in   asynchronous active-high reset
//   E, Q   in   CPU bus phases; a write commits on the Q falling edge inside E
//   ADDR   in   CPU address bus
//   RnW    in   CPU read/not-write
//   DIN    in   CPU write data
//   DRD    out  read data (combinational)
//   DRD_OE out  read-data select enable (combinational)
//   SRC    in   asynchronous interrupt requests, active-high
//   nIRQ   out  active-low IRQ, registered
//   nFIRQ  out  active-low FIRQ, registered
module mc6809_irq_ctrl #(
    parameter logic [15:0] BASE_ADDR = 16'hFF40
) (
    input  logic        CLK4,
    input  logic        RESET,
    input  logic        E,
    input  logic        Q,
    input  logic [15:0] ADDR,
    input  logic        RnW,
    input  logic [7:0]  DIN,
    output logic [7:0]  DRD,
    output logic        DRD_OE,
    input  logic [7:0]  SRC,
    output logic        nIRQ,
    output logic        nFIRQ
);

    localparam int unsigned NSRC = 8;
    localparam int unsigned OFFW = 3;

    localparam logic [OFFW-1:0] OFF_PEND   = 3'd0;
    localparam logic [OFFW-1:0] OFF_MASK   = 3'd1;
    localparam logic [OFFW-1:0] OFF_EDGE   = 3'd2;
    localparam logic [OFFW-1:0] OFF_ROUTE  = 3'd3;
`ifdef IRQC_VECTOR_EN
    localparam logic [OFFW-1:0] OFF_VECTOR = 3'd4;
`endif

    // Synchronizer stages; s3 is kept only for rising-edge detection.
    logic [NSRC-1:0] s1;
    logic [NSRC-1:0] s2;
    logic [NSRC-1:0] s3;

    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] edge_sel;
    logic [NSRC-1:0] route;
    logic            q_d;

    logic            hit;
    logic [OFFW-1:0] off;
    logic            wr_en;
    logic [NSRC-1:0] act;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] pend_next;
    logic [7:0]      rd_data;

    // Address decode: eight-byte window aligned on BASE_ADDR.
    assign hit = (ADDR[15:OFFW] == BASE_ADDR[15:OFFW]);
    assign off = ADDR[OFFW-1:0];

    // Q falling while E is high happens once per bus cycle.
    assign wr_en = q_d & ~Q & E & hit & ~RnW;

    assign act  = pend & mask;
    assign rise = s2 & ~s3;

    // Pending next-state: edge bits latch rises and honour W1C (set wins),
    // level bits simply follow the synchronized input.
    always_comb begin
        w1c       = '0;
        pend_next = '0;
        if (wr_en && (off == OFF_PEND)) begin
            w1c = DIN;
        end
        pend_next = (edge_sel & ((pend & ~w1c) | rise)) | (~edge_sel & s2);
    end

`ifdef IRQC_VECTOR_EN
    // Lowest-numbered active source wins; bit 7 flags any active source.
    logic [7:0] vector;

    always_comb begin
        vector = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (act[i]) begin
                vector[2:0] = 3'(i);
            end
        end
        vector[7] = |act;
    end
`endif

    // Read-data mux; unused offsets read as zero.
    always_comb begin
        rd_data = '0;
        case (off)
            OFF_PEND:   rd_data = pend;
            OFF_MASK:   rd_data = mask;
            OFF_EDGE:   rd_data = edge_sel;
            OFF_ROUTE:  rd_data = route;
`ifdef IRQC_VECTOR_EN
            OFF_VECTOR: rd_data = vector;
`endif
            default:    rd_data = '0;
        endcase
    end

    assign DRD    = hit ? rd_data : 8'h00;
    assign DRD_OE = hit & RnW & E;

    // Synchronizer, bus strobe history and interrupt outputs.
    always_ff @(posedge CLK4 or posedge RESET) begin
        if (RESET) begin
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            q_d   <= 1'b0;
            nIRQ  <= 1'b1;
            nFIRQ <= 1'b1;
        end else begin
            s1    <= SRC;
            s2    <= s1;
            s3    <= s2;
            q_d   <= Q;
            nIRQ  <= ~|(act & ~route);
            nFIRQ <= ~|(act & route);
        end
    end

    // Register file.
    always_ff @(posedge CLK4 or posedge RESET) begin
        if (RESET) begin
            pend     <= '0;
            mask     <= '0;
            edge_sel <= '0;
            route    <= '0;
        end else begin
            pend <= pend_next;
            if (wr_en) begin
                case (off)
                    OFF_MASK:  mask     <= DIN;
                    OFF_EDGE:  edge_sel <= DIN;
                    OFF_ROUTE: route    <= DIN;
                    default:   ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mc6809_irq_ctrl.sv
`timescale 1ns/1ps
module tb_mc6809_irq_ctrl;

    localparam logic [15:0] BASE = 16'hFF40;

    logic        CLK4 = 1'b0;
    logic        RESET;
    logic        E;
    logic        Q;
    logic [15:0] ADDR;
    logic        RnW;
    logic [7:0]  DIN;
    logic [7:0]  SRC;
    logic [7:0]  DRD;
    logic        DRD_OE;
    logic        nIRQ;
    logic        nFIRQ;

    int n_vec = 0;
    int n_err = 0;
    bit rand_src = 1'b0;

    mc6809_irq_ctrl #(.BASE_ADDR(BASE)) dut (
        .CLK4(CLK4), .RESET(RESET), .E(E), .Q(Q), .ADDR(ADDR), .RnW(RnW),
        .DIN(DIN), .DRD(DRD), .DRD_OE(DRD_OE), .SRC(SRC),
        .nIRQ(nIRQ), .nFIRQ(nFIRQ)
    );

    always #5 CLK4 = ~CLK4;

    // Reference model: registers plus a short history of sampled SRC values.
    logic [7:0] m_pend, m_mask, m_edge, m_route;
    logic       m_nirq, m_nfirq, m_qd;
    logic [7:0] hist [3];   // hist[0] = SRC at last posedge, hist[1] one before, ...

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_edge = 0; m_route = 0;
        m_nirq = 1'b1; m_nfirq = 1'b1; m_qd = 1'b0;
        for (int i = 0; i < 3; i++) hist[i] = 8'h00;
    endtask

    function automatic bit in_window(input logic [15:0] a);
        return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + 8);
    endfunction

    function automatic logic [7:0] m_read(input int o);
        logic [7:0] v;
        logic [7:0] a;
        v = 8'h00;
        a = m_pend & m_mask;
        case (o)
            0: v = m_pend;
            1: v = m_mask;
            2: v = m_edge;
            3: v = m_route;
`ifdef IRQC_VECTOR_EN
            4: begin
                if (a != 0) begin
                    v = 8'h80;
                    for (int i = 7; i >= 0; i--) if (a[i]) v = 8'h80 + 8'(i);
                end
            end
`endif
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    task automatic model_step();
        logic [7:0] a;
        logic [7:0] np;
        bit         commit;
        int         o;
        if (RESET) begin
            model_reset();
            return;
        end
        a = m_pend & m_mask;
        commit = m_qd && !Q && E && !RnW && in_window(ADDR);
        o = int'(ADDR) - int'(BASE);
        np = m_pend;
        for (int i = 0; i < 8; i++) begin
            if (m_edge[i]) begin
                if (hist[1][i] && !hist[2][i]) np[i] = 1'b1;
                else if (commit && o == 0 && DIN[i]) np[i] = 1'b0;
            end else begin
                np[i] = hist[1][i];
            end
        end
        m_nirq  = ((a & ~m_route) == 8'h00);
        m_nfirq = ((a & m_route) == 8'h00);
        m_pend  = np;
        if (commit) begin
            if (o == 1) m_mask  = DIN;
            if (o == 2) m_edge  = DIN;
            if (o == 3) m_route = DIN;
        end
        m_qd = Q;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = SRC;
    endtask

    // One clock: optional random SRC change, posedge, model update, back to negedge.
    task automatic tick();
        if (rand_src && $urandom_range(0, 2) == 0)
            SRC = SRC ^ 8'(1 << $urandom_range(0, 7));
        @(posedge CLK4);
        model_step();
        @(negedge CLK4);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_idle();
        E = 1'b0; Q = 1'b0; RnW = 1'b1; ADDR = 16'h0000; DIN = 8'h00;
    endtask

    // Four-phase bus write; SRC may be set to src_val before phase src_phase.
    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data,
                             input int src_phase, input logic [7:0] src_val);
        for (int p = 0; p < 4; p++) begin
            if (p == src_phase) SRC = src_val;
            ADDR = addr; RnW = 1'b0; DIN = data;
            E = (p >= 2); Q = (p == 1 || p == 2);
            tick();
        end
        bus_idle();
    endtask

    task automatic wr(input int o, input logic [7:0] data);
        bus_write(BASE + 16'(o), data, -1, 8'h00);
    endtask

    // Four-phase bus read; returns data and the model value at the sample point.
    task automatic bus_read(input logic [15:0] addr, output logic [7:0] d,
                            output logic [7:0] expv, output logic oe_lo,
                            output logic oe_hi);
        for (int p = 0; p < 4; p++) begin
            ADDR = addr; RnW = 1'b1;
            E = (p >= 2); Q = (p == 1 || p == 2);
            if (p == 2) begin
                #1;
                d = DRD; oe_hi = DRD_OE;
                expv = m_read(int'(addr) - int'(BASE));
            end
            tick();
            if (p == 1) oe_lo = DRD_OE;
        end
        bus_idle();
    endtask

    task automatic test_reset();
        logic [7:0] d, ev;
        logic oe0, oe1;
        RESET = 1'b1; SRC = 8'h00; bus_idle(); model_reset();
        ticks(3);
        n_vec++; if (nIRQ !== 1'b1)  begin n_err++; $display("FAIL reset_nirq got %b want 1", nIRQ); end
        n_vec++; if (nFIRQ !== 1'b1) begin n_err++; $display("FAIL reset_nfirq got %b want 1", nFIRQ); end
        n_vec++; if (DRD_OE !== 1'b0) begin n_err++; $display("FAIL reset_oe got %b want 0", DRD_OE); end
        RESET = 1'b0;
        ticks(2);
        for (int o = 0; o < 8; o++) begin
            bus_read(BASE + 16'(o), d, ev, oe0, oe1);
            n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_reg%0d got %h want 00", o, d); end
        end
    endtask

    task automatic test_edge_irq();
        logic [7:0] d, ev;
        logic oe0, oe1;
        wr(2, 8'h01); wr(1, 8'h01); wr(3, 8'h00);
        SRC = 8'h01;
        ticks(2);
        SRC = 8'h00;
        tick();
        n_vec++; if (nIRQ !== 1'b1) begin n_err++; $display("FAIL edge_lat_early got %b want 1", nIRQ); end
        tick();
        n_vec++; if (nIRQ !== 1'b0) begin n_err++; $display("FAIL edge_lat got %b want 0", nIRQ); end
        n_vec++; if (nFIRQ !== 1'b1) begin n_err++; $display("FAIL edge_nfirq got %b want 1", nFIRQ); end
        bus_read(BASE, d, ev, oe0, oe1);
        n_vec++; if (d !== 8'h01) begin n_err++; $display("FAIL edge_pend got %h want 01", d); end
        wr(0, 8'h01);
        n_vec++; if (nIRQ !== 1'b0) begin n_err++; $display("FAIL w1c_early got %b want 0", nIRQ); end
        tick();
        n_vec++; if (nIRQ !== 1'b1) begin n_err++; $display("FAIL w1c_release got %b want 1", nIRQ); end
    endtask

    task automatic test_level_firq();
        wr(2, 8'h00); wr(1, 8'h80); wr(3, 8'h80);
        SRC = 8'h80;
        ticks(4);
        n_vec++; if (nFIRQ !== 1'b0) begin n_err++; $display("FAIL level_nfirq got %b want 0", nFIRQ); end
        n_vec++; if (nIRQ !== 1'b1)  begin n_err++; $display("FAIL level_nirq got %b want 1", nIRQ); end
        wr(0, 8'h80);
        tick();
        n_vec++; if (nFIRQ !== 1'b0) begin n_err++; $display("FAIL level_w1c got %b want 0", nFIRQ); end
        SRC = 8'h00;
        ticks(3);
        n_vec++; if (nFIRQ !== 1'b0) begin n_err++; $display("FAIL level_rel_early got %b want 0", nFIRQ); end
        tick();
        n_vec++; if (nFIRQ !== 1'b1) begin n_err++; $display("FAIL level_release got %b want 1", nFIRQ); end
    endtask

    task automatic test_collision();
        logic [7:0] d, ev;
        logic oe0, oe1;
        wr(2, 8'h04); wr(1, 8'h04); wr(3, 8'h00);
        SRC = 8'h04; ticks(2); SRC = 8'h00; ticks(4);
        bus_read(BASE, d, ev, oe0, oe1);
        n_vec++; if (d !== 8'h04) begin n_err++; $display("FAIL coll_setup got %h want 04", d); end
        // Rise sampled two posedges before the W1C commit.
        bus_write(BASE, 8'h04, 1, 8'h04);
        ticks(2); SRC = 8'h00; ticks(2);
        bus_read(BASE, d, ev, oe0, oe1);
        n_vec++; if (d !== 8'h04) begin n_err++; $display("FAIL coll_setwins got %h want 04", d); end
        n_vec++; if (nIRQ !== 1'b0) begin n_err++; $display("FAIL coll_nirq got %b want 0", nIRQ); end
        wr(0, 8'h04);
        bus_read(BASE, d, ev, oe0, oe1);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL coll_clear got %h want 00", d); end
    endtask

    task automatic test_decode();
        logic [7:0] d, ev;
        logic oe0, oe1;
        wr(1, 8'h5A); wr(2, 8'h00); wr(3, 8'h00);
        bus_write(BASE + 16'd8, 8'hFF, -1, 8'h00);
        bus_write(BASE - 16'd1, 8'hFF, -1, 8'h00);
        wr(5, 8'hFF);
        bus_read(BASE + 16'd1, d, ev, oe0, oe1);
        n_vec++; if (d !== 8'h5A) begin n_err++; $display("FAIL decode_mask got %h want 5a", d); end
        n_vec++; if (oe1 !== 1'b1) begin n_err++; $display("FAIL oe_hit got %b want 1", oe1); end
        n_vec++; if (oe0 !== 1'b0) begin n_err++; $display("FAIL oe_e_low got %b want 0", oe0); end
        for (int o = 0; o < 8; o++) begin
            bus_read(BASE + 16'(o), d, ev, oe0, oe1);
            n_vec++; if (d !== ev) begin n_err++; $display("FAIL decode_reg%0d got %h want %h", o, d, ev); end
        end
        bus_read(BASE + 16'd5, d, ev, oe0, oe1);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL off5 got %h want 00", d); end
`ifndef IRQC_VECTOR_EN
        bus_read(BASE + 16'd4, d, ev, oe0, oe1);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL off4 got %h want 00", d); end
`endif
        bus_read(BASE + 16'd8, d, ev, oe0, oe1);
        n_vec++; if (oe1 !== 1'b0) begin n_err++; $display("FAIL oe_above got %b want 0", oe1); end
        bus_read(BASE - 16'd1, d, ev, oe0, oe1);
        n_vec++; if (oe1 !== 1'b0) begin n_err++; $display("FAIL oe_below got %b want 0", oe1); end
    endtask

    task automatic test_strobe();
        logic [7:0] d, ev;
        logic oe0, oe1;
        // E held high past the Q fall with new data: only the first value commits.
        for (int p = 0; p < 6; p++) begin
            ADDR = BASE + 16'd1; RnW = 1'b0;
            DIN = (p < 4) ? 8'hA3 : 8'h3C;
            E = (p >= 2); Q = (p == 1 || p == 2);
            tick();
        end
        bus_idle();
        bus_read(BASE + 16'd1, d, ev, oe0, oe1);
        n_vec++; if (d !== 8'hA3) begin n_err++; $display("FAIL strobe_once got %h want a3", d); end
        wr(1, 8'h00); wr(2, 8'h00); wr(3, 8'h00);
        SRC = 8'h01; ticks(4);
        n_vec++; if (nIRQ !== 1'b1) begin n_err++; $display("FAIL mask_off got %b want 1", nIRQ); end
        wr(1, 8'h01);
        n_vec++; if (nIRQ !== 1'b1) begin n_err++; $display("FAIL mask_commit_early got %b want 1", nIRQ); end
        tick();
        n_vec++; if (nIRQ !== 1'b0) begin n_err++; $display("FAIL mask_commit got %b want 0", nIRQ); end
    endtask

    task automatic test_async_reset();
        wr(2, 8'h00); wr(1, 8'h01); wr(3, 8'h00);
        SRC = 8'h01; ticks(4);
        ADDR = BASE + 16'd1;
        n_vec++; if (nIRQ !== 1'b0) begin n_err++; $display("FAIL pre_reset got %b want 0", nIRQ); end
        #2 RESET = 1'b1;
        model_reset();
        #1;
        n_vec++; if (nIRQ !== 1'b1) begin n_err++; $display("FAIL async_nirq got %b want 1", nIRQ); end
        n_vec++; if (nFIRQ !== 1'b1) begin n_err++; $display("FAIL async_nfirq got %b want 1", nFIRQ); end
        n_vec++; if (DRD !== 8'h00) begin n_err++; $display("FAIL async_drd got %h want 00", DRD); end
        n_vec++; if (DRD_OE !== 1'b0) begin n_err++; $display("FAIL async_oe got %b want 0", DRD_OE); end
        @(negedge CLK4);
        tick();
        RESET = 1'b0;
        SRC = 8'h00;
        ticks(4);
    endtask

`ifdef IRQC_VECTOR_EN
    task automatic test_vector();
        logic [7:0] d, ev;
        logic oe0, oe1;
        wr(2, 8'hFF); wr(0, 8'hFF); wr(3, 8'h00); wr(1, 8'hFF);
        SRC = 8'h28; ticks(2); SRC = 8'h00; ticks(3);
        bus_read(BASE + 16'd4, d, ev, oe0, oe1);
        n_vec++; if (d !== 8'h83) begin n_err++; $display("FAIL vec_both got %h want 83", d); end
        wr(0, 8'h08);
        bus_read(BASE + 16'd4, d, ev, oe0, oe1);
        n_vec++; if (d !== 8'h85) begin n_err++; $display("FAIL vec_five got %h want 85", d); end
        wr(0, 8'h20);
        bus_read(BASE + 16'd4, d, ev, oe0, oe1);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL vec_none got %h want 00", d); end
    endtask
`endif

    task automatic test_random();
        logic [7:0] d, ev;
        logic oe0, oe1;
        logic [15:0] a;
        int r;
        rand_src = 1'b1;
        for (int it = 0; it < 400; it++) begin
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 5) == 0) a = BASE + 16'($urandom_range(8, 15));
            else                           a = BASE + 16'($urandom_range(0, 7));
            if (r < 4) begin
                bus_write(a, 8'($urandom_range(0, 255)), -1, 8'h00);
            end else if (r < 7) begin
                bus_read(a, d, ev, oe0, oe1);
                n_vec++; if (oe1 !== 1'(in_window(a))) begin n_err++; $display("FAIL rnd_oe addr %h got %b", a, oe1); end
                if (in_window(a)) begin
                    n_vec++; if (d !== ev) begin n_err++; $display("FAIL rnd_read addr %h got %h want %h", a, d, ev); end
                end
            end else begin
                tick();
            end
            n_vec++; if (nIRQ !== m_nirq)   begin n_err++; $display("FAIL rnd_nirq it %0d got %b want %b", it, nIRQ, m_nirq); end
            n_vec++; if (nFIRQ !== m_nfirq) begin n_err++; $display("FAIL rnd_nfirq it %0d got %b want %b", it, nFIRQ, m_nfirq); end
        end
        rand_src = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; SRC = 8'h00; bus_idle(); model_reset();
        @(negedge CLK4);
        test_reset();
        test_edge_irq();
        test_level_firq();
        test_collision();
        test_decode();
        test_strobe();
        test_async_reset();
`ifdef IRQC_VECTOR_EN
        test_vector();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
